vc_ibuf: RTL

Per-virtual-channel input buffer of a router input port. It accepts flits from the link, stores them in a FIFO, and computes the XY output port from each head flit. It holds a request to the downstream VC multiplexer for the whole packet, and on each grant it emits one registered flit plus a credit back to the upstream router. One instance exists per VC; each instance drives one `ovalid/odata/ovch/req/port` input group of the VC mux.

---
 rtl/vc_ibuf.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vc_ibuf.sv
// Per-VC router input buffer: flit FIFO, XY route computation on head flits,
// packet-long request to the VC mux, registered flit output with upstream credit.
//
// state  | meaning
// IDLE   | no packet in flight; inspects the FIFO head for a new packet
// ACTIVE | packet owns the VC mux request; flits leave on grt & ordy
module vc_ibuf #(
   parameter int DATA_W = 34,
   parameter int DEPTH  = 4,
   parameter int VCH_W  = 1,
   parameter int VCH_ID = 0,
   parameter int PORT_W = 3,
   parameter int MY_X   = 0,
   parameter int MY_Y   = 0
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              ivalid,
   input  logic [DATA_W-1:0] idata,
   input  logic              grt,
   input  logic              ordy,
   output logic              ovalid,
   output logic [DATA_W-1:0] odata,
   output logic [VCH_W-1:0]  ovch,
   output logic              req,
   output logic [PORT_W-1:0] port,
   output logic              credit,
   output logic              ovf,
   output logic              perr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              in_pkt;
   logic              empty;
   logic              full;
   logic              pop_fwd;
   logic              pop_drop;
   logic              pop;
   logic              push;
   logic [DATA_W-1:0] head;
   logic [1:0]        head_type;
   logic [3:0]        dst_x;
   logic [3:0]        dst_y;
   logic [PORT_W-1:0] route;

   assign head      = mem[rd_ptr];
   assign head_type = head[DATA_W-1 -: 2];
   assign dst_x     = head[3:0];
   assign dst_y     = head[7:4];
   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));

   // Type bit 0 set means the flit opens a packet (head or head+tail).
   assign pop_fwd  = (state == ACTIVE) && grt && ordy && !empty;
   assign pop_drop = (state == IDLE) && !empty && !head_type[0];
   assign pop      = pop_fwd | pop_drop;
   assign push     = ivalid && (!full || pop);

   assign ovch = VCH_W'(VCH_ID);

   always_comb begin
      route = PORT_W'(0);
      if (dst_x > 4'(MY_X))
         route = PORT_W'(2);
      else if (dst_x < 4'(MY_X))
         route = PORT_W'(4);
      else if (dst_y > 4'(MY_Y))
         route = PORT_W'(1);
      else if (dst_y < 4'(MY_Y))
         route = PORT_W'(3);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= idata;
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state  <= IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         in_pkt <= 1'b0;
         ovalid <= 1'b0;
         odata  <= '0;
         credit <= 1'b0;
         req    <= 1'b0;
         port   <= '0;
         ovf    <= 1'b0;
         perr   <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (ivalid && full && !pop)
            ovf <= 1'b1;

         ovalid <= pop_fwd;
         credit <= pop_fwd;
         if (pop_fwd)
            odata <= head;

         case (state)
            IDLE: begin
               if (!empty) begin
                  if (head_type[0]) begin
                     port   <= route;
                     req    <= 1'b1;
                     in_pkt <= 1'b0;
                     state  <= ACTIVE;
                  end else begin
                     perr <= 1'b1;
                  end
               end
            end
            ACTIVE: begin
               if (pop_fwd) begin
                  in_pkt <= 1'b1;
                  // A second head inside a packet is flagged but still forwarded.
                  if (in_pkt && head_type[0])
                     perr <= 1'b1;
                  if (head_type[1]) begin
                     req   <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
